fir_sample_fifo: RTL and testbench

//  Downstream capture stage for the 3-tap FIR output. Takes the filter's 8-bit y

---
 rtl/fir_sample_fifo.sv | 134 +++++++++++++
 tb/tb_fir_sample_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_fifo.sv
// Decimating capture FIFO behind the 3-tap FIR: keeps every DECIM-th valid sample
// and drains it over valid/ready. Optional macro FIR_FIFO_STATS_EN adds drop_cnt.
module fir_sample_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DECIM = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow
`ifdef FIR_FIFO_STATS_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [7:0]    PHASE_LAST = 8'(DECIM - 1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [7:0]    phase_r;
  logic          overflow_r;

  logic          valid_s;
  logic          full_s;
  logic          kept_s;
  logic          rd_s;
  logic          wr_s;
  logic          drop_s;

  // Handshake decode: a full FIFO still accepts a kept sample when a read frees a slot
  always_comb begin
    valid_s = 1'b0;
    full_s  = 1'b0;
    kept_s  = 1'b0;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    drop_s  = 1'b0;
    if (count_r != {(AW+1){1'b0}}) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    if (count_r == DEPTH_C) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (in_valid && (phase_r == 8'd0)) begin
      kept_s = 1'b1;
    end else begin
      kept_s = 1'b0;
    end
    rd_s   = valid_s && out_ready;
    wr_s   = kept_s && (!full_s || rd_s);
    drop_s = kept_s && full_s && !rd_s;
  end

  // Pointers, occupancy, decimation phase and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      phase_r    <= 8'd0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (in_valid) begin
        if (phase_r == PHASE_LAST) begin
          phase_r <= 8'd0;
        end else begin
          phase_r <= phase_r + 8'd1;
        end
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Sample storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

`ifdef FIR_FIFO_STATS_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of dropped kept samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  // Head is forced to zero when empty so reset and idle show a clean bus
  assign out_data  = valid_s ? mem_r[rd_ptr_r] : {DW{1'b0}};
  assign out_valid = valid_s;
  assign count     = count_r;
  assign full      = full_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Bench for fir_sample_fifo: instance 0 uses DECIM=1, instance 1 uses DECIM=3,
// both checked every cycle against a queue model plus literal expectations.
module tb_fir_sample_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic [7:0] od  [2];
  logic       ov  [2];
  logic [3:0] cnt [2];
  logic       fl  [2];
  logic       ovf [2];
`ifdef FIR_FIFO_STATS_EN
  logic [7:0] dc  [2];
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] mq [2][$];
  int         mph [2];
  bit         movf [2];
  int         mdrop [2];

  always #5 clk = ~clk;

  fir_sample_fifo #(.DW(8), .DEPTH(8), .AW(3), .DECIM(1)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .count(cnt[0]), .full(fl[0]), .overflow(ovf[0])
`ifdef FIR_FIFO_STATS_EN
    , .drop_cnt(dc[0])
`endif
  );

  fir_sample_fifo #(.DW(8), .DEPTH(8), .AW(3), .DECIM(3)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .count(cnt[1]), .full(fl[1]), .overflow(ovf[1])
`ifdef FIR_FIFO_STATS_EN
    , .drop_cnt(dc[1])
`endif
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int decim_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mph[k]   = 0;
      movf[k]  = 1'b0;
      mdrop[k] = 0;
    end
  endtask

  // Expected state after the coming rising edge for the given inputs
  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    bit rd, kept, wr;
    if (!reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        rd   = (mq[k].size() != 0) && r;
        kept = v && (mph[k] == 0);
        wr   = kept && ((mq[k].size() < 8) || rd);
        if (rd) void'(mq[k].pop_front());
        if (wr) mq[k].push_back(d);
        if (kept && !wr) begin
          movf[k] = 1'b1;
          if (mdrop[k] < 255) mdrop[k]++;
        end
        if (v) mph[k] = (mph[k] + 1) % decim_of(k);
      end
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), int'(ov[k]), int'(mq[k].size() != 0));
      chk($sformatf("count%0d", k), int'(cnt[k]), mq[k].size());
      chk($sformatf("full%0d", k), int'(fl[k]), int'(mq[k].size() == 8));
      chk($sformatf("ovf%0d", k), int'(ovf[k]), int'(movf[k]));
`ifdef FIR_FIFO_STATS_EN
      chk($sformatf("drop%0d", k), int'(dc[k]), mdrop[k]);
`endif
      if (mq[k].size() != 0) begin
        chk($sformatf("data%0d", k), int'(od[k]), int'(mq[k][0]));
      end else if (!reset) begin
        chk($sformatf("rstdata%0d", k), int'(od[k]), 0);
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    model_step(v, d, r);
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    model_reset();
    #1;
    chk("async_valid", int'(ov[0]), 0);
    chk("async_count", int'(cnt[0]), 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  int l5 [5] = '{0, 3, 6, 60, 63};

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd7;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    // Reset held with valid input
    step(1'b1, 8'd7, 1'b0);
    step(1'b1, 8'd8, 1'b0);
    chk("rst_count", int'(cnt[0]), 0);
    chk("rst_data", int'(od[0]), 0);
    chk("rst_ovf", int'(ovf[0]), 0);
    reset = 1'b1;
    step(1'b1, 8'd42, 1'b0);
    chk("first_kept0", int'(od[0]), 42);
    chk("first_kept1", int'(od[1]), 42);
    chk("first_cnt", int'(cnt[0]), 1);
    step(1'b0, 8'd0, 1'b1);

    // Streaming with a ready sink
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i), 1'b1);
      chk("stream_data", int'(od[0]), i);
      chk("stream_cnt", int'(cnt[0]), 1);
    end
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);

    // Fill, overflow, drain
    reset_pulse();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(10 + i), 1'b0);
    chk("fill_full", int'(fl[0]), 1);
    chk("fill_cnt", int'(cnt[0]), 8);
    step(1'b1, 8'd18, 1'b0);
    chk("drop_ovf", int'(ovf[0]), 1);
    chk("drop_cnt_kept", int'(cnt[0]), 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", int'(od[0]), 10 + i);
      step(1'b0, 8'd0, 1'b1);
    end
    chk("drain_empty", int'(ov[0]), 0);

    // Full with simultaneous read and write
    reset_pulse();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(10 + i), 1'b0);
    step(1'b1, 8'd99, 1'b1);
    chk("rw_cnt", int'(cnt[0]), 8);
    chk("rw_ovf", int'(ovf[0]), 0);
    chk("rw_head", int'(od[0]), 11);
    for (int i = 0; i < 8; i++) begin
      chk("rw_drain", int'(od[0]), (i < 7) ? 11 + i : 99);
      step(1'b0, 8'd0, 1'b1);
    end

    // Decimation by 3 with input gaps
    reset_pulse();
    for (int i = 0; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    chk("dec_cnt", int'(cnt[1]), 3);
    step(1'b1, 8'd60, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd61, 1'b0);
    step(1'b1, 8'd62, 1'b0);
    step(1'b1, 8'd63, 1'b0);
    chk("dec_cnt_gap", int'(cnt[1]), 5);
    for (int i = 0; i < 5; i++) begin
      chk("dec_data", int'(od[1]), l5[i]);
      step(1'b0, 8'd0, 1'b1);
    end
    chk("dec_empty", int'(ov[1]), 0);

    // Mid-operation reset, then pointer wrap
    reset_pulse();
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    chk("mid_cnt", int'(cnt[0]), 5);
    reset_pulse();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(100 + i), 1'b0);
    for (int i = 3; i < 20; i++) begin
      step(1'b1, 8'(100 + i), 1'b1);
      chk("wrap_cnt", int'(cnt[0]), 3);
    end
    for (int i = 0; i < 3; i++) begin
      chk("wrap_data", int'(od[0]), 117 + i);
      step(1'b0, 8'd0, 1'b1);
    end
    chk("wrap_empty", int'(ov[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
